// File: rtl/accum_pkg.sv
// Shared constants and state encoding for the sample accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package accum_pkg;

    localparam int SAMPLE_W = 4;
    localparam int SUM_W    = 6;
    localparam int CNT_W    = 2;
    localparam int REM_W    = CNT_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/accum_ctrl_add.sv
// Zero-extending adder: sample plus running accumulator.
// Latency: combinational.
// Backpressure: none.
module Add
    import accum_pkg::*;
(
    input  logic [SAMPLE_W-1:0] LSC_In,
    input  logic [SUM_W-1:0]    Mul_In,
    output logic [SUM_W-1:0]    Add_Out
);

    // Four 4-bit samples top out at 60, so the 6-bit sum never wraps.
    assign Add_Out = {{(SUM_W-SAMPLE_W){1'b0}}, LSC_In} + Mul_In;

endmodule

// File: rtl/accum_ctrl.sv
// Accumulates 1..4 unsigned samples per run and publishes the sum.
// Latency: Done_Out pulses the cycle after the final accepted sample.
// Backpressure: Ready_Out high only in ACCUM; Valid_In gaps stall the run.
module accum_ctrl
    import accum_pkg::*;
(
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Start_In,
    input  logic [CNT_W-1:0]    Count_In,
    input  logic [SAMPLE_W-1:0] Data_In,
    input  logic                Valid_In,
    output logic                Ready_Out,
    output logic                Busy_Out,
    output logic [SUM_W-1:0]    Sum_Out,
    output logic                Done_Out
);

    state_t             state_q, state_nxt;
    logic [SUM_W-1:0]   acc_q, acc_nxt;
    logic [REM_W-1:0]   rem_q, rem_nxt;
    logic [SUM_W-1:0]   sum_q, sum_nxt;
    logic [SUM_W-1:0]   add_res;
    logic               beat;

    Add u_add (
        .LSC_In  (Data_In),
        .Mul_In  (acc_q),
        .Add_Out (add_res)
    );

    assign beat    = Valid_In & Ready_Out;
    assign Sum_Out = sum_q;

    // Next-state and register updates; status outputs decode the state only.
    always_comb begin
        state_nxt = state_q;
        acc_nxt   = acc_q;
        rem_nxt   = rem_q;
        sum_nxt   = sum_q;
        Ready_Out = 1'b0;
        Busy_Out  = 1'b0;
        Done_Out  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start_In) begin
                    state_nxt = ST_ACCUM;
                    acc_nxt   = '0;
                    rem_nxt   = {1'b0, Count_In} + REM_W'(1);
                end
            end
            ST_ACCUM: begin
                Ready_Out = 1'b1;
                Busy_Out  = 1'b1;
                // Ready_Out is 1 here, so Valid_In alone marks a beat.
                if (Valid_In) begin
                    acc_nxt = add_res;
                    rem_nxt = rem_q - REM_W'(1);
                    if (rem_q == REM_W'(1)) begin
                        sum_nxt   = add_res;
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                Busy_Out  = 1'b1;
                Done_Out  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // All state in one register process; reset wins over start and beats.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_nxt;
            acc_q   <= acc_nxt;
            rem_q   <= rem_nxt;
            sum_q   <= sum_nxt;
        end
    end

endmodule

// File: doc/accum_ctrl.md
ACCUM_CTRL -- requirements
Module: accum_ctrl

Interface
REQ-001 Parameters: none; SAMPLE_W = 4 and SUM_W = 6 are fixed constants from the shared package.
REQ-002 Clk  input  1  single clock; all state changes on rising edge.
REQ-003 Rst  input  1  reset, synchronous, active-high.
REQ-004 Start_In  input  1  request a new accumulation run; sampled only in IDLE.
REQ-005 Count_In  input  2  number of samples minus one (0..3 -> 1..4 samples); captured with accepted Start_In.
REQ-006 Data_In  input  4  unsigned sample.
REQ-007 Valid_In  input  1  Data_In valid this cycle.
REQ-008 Ready_Out  output  1  block accepts a sample this cycle.
REQ-009 Busy_Out  output  1  run in progress (ACCUM or DONE).
REQ-010 Sum_Out  output  6  result of last completed run.
REQ-011 Done_Out  output  1  one-cycle pulse: Sum_Out just updated.

Function
REQ-012 FSM states IDLE, ACCUM, DONE; encoding is the package enum.
REQ-013 IDLE: Ready_Out=0, Busy_Out=0; Start_In=1 -> ACCUM, accumulator <= 0, remaining <= Count_In+1 (3-bit).
REQ-014 Start_In in ACCUM or DONE is ignored; it does not restart, extend or alter the run.
REQ-015 ACCUM: Ready_Out=1 (decoded from state, no input dependence), Busy_Out=1.
REQ-016 Beat = Valid_In & Ready_Out at a rising edge; Data_In is ignored when no beat occurs.
REQ-017 On a beat: accumulator <= Data_In + accumulator (6-bit), remaining <= remaining-1.
REQ-018 On a beat with remaining==1: Sum_Out <= Data_In + accumulator, state -> DONE.
REQ-019 DONE: Done_Out=1, Ready_Out=0, Busy_Out=1 for exactly one cycle; then -> IDLE unconditionally.
REQ-020 Done_Out is 0 in every state other than DONE.
REQ-021 Latency: Done_Out high the cycle after the final beat; with Valid_In held high, N samples complete in N+1 cycles after Start acceptance.
REQ-022 Sum_Out holds its value from the end of one run until the final beat of the next; it is not cleared by Start_In.
REQ-023 Arithmetic unsigned, zero-extended 4->6 bits; max 4x15=60 < 64, so no overflow or saturation logic.
REQ-024 Valid_In gaps in ACCUM stall the run indefinitely without changing accumulator, remaining or Sum_Out.
REQ-025 Earliest new Start_In acceptance is the IDLE cycle after DONE.

Reset
REQ-026 Rst=1 at a rising edge: state IDLE, accumulator 0, remaining 0, Sum_Out 0; hence Done_Out 0, Ready_Out 0, Busy_Out 0.
REQ-027 Rst has priority over Start_In and beats in the same cycle.
REQ-028 Rst mid-run aborts: no Done_Out pulse, partial sum discarded, Sum_Out 0.

Structure
REQ-029 Package accum_pkg holds SAMPLE_W, SUM_W, CNT_W=2 and the state enum type.
REQ-030 Addition is performed by one instance of the existing Add module (LSC_In=Data_In, Mul_In=accumulator); accum_ctrl contains no separate adder.
REQ-031 All registers in one clocked process; Ready_Out, Busy_Out and Done_Out are state decodes.

Verification
REQ-032 Rst 2 cycles -> all outputs 0, state IDLE; Valid_In=1 with Data_In=9 in IDLE -> no change.
REQ-033 Start, Count_In=3, Valid_In held high, Data 15,15,15,15 -> Done_Out pulse 5 cycles after start, Sum_Out=60.
REQ-034 Start, Count_In=0, Data 7 -> Sum_Out=7, Done_Out 2 cycles after start; next IDLE cycle Start accepted.
REQ-035 Count_In=2, Data 3, gap 4 cycles Valid_In=0, 5, 6 -> Sum_Out=14 once; Start_In pulsed during the gap is ignored.
REQ-036 Count_In=3, Rst asserted after 2 beats -> no Done_Out, Sum_Out=0; fresh run Count_In=1, Data 10,1 -> Sum_Out=11.
REQ-037 Run A sum 20, then Start of run B -> Sum_Out stays 20 until B's final beat, then B's sum.
